// File: rtl/spi_slave_cmd_decoder.sv
// SPI/QPI slave command decoder.
// Shifts in a CMD_WIDTH-bit command (1 or 4 bits per sclk), decodes the low
// byte into phase controls, and keeps a saturating count of bad commands.
module spi_slave_cmd_decoder #(
    parameter int CMD_WIDTH    = 8,
    parameter int NUM_REGS     = 4,
    parameter int DUMMY_CYCLES = 8,
    parameter int ERR_CNT_W    = 8,
    localparam int RS_W        = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  sclk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  qpi_mode,
    input  logic [3:0]            sdi,
    input  logic                  err_clr,
    output logic                  cmd_valid,
    output logic [CMD_WIDTH-1:0]  cmd,
    output logic                  get_addr,
    output logic                  get_mode,
    output logic                  get_data,
    output logic                  send_data,
    output logic                  enable_cont,
    output logic                  enable_regs,
    output logic                  wait_dummy,
    output logic                  error,
    output logic [RS_W-1:0]       reg_sel,
    output logic [7:0]            dummy_cycles,
    output logic                  busy,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    localparam int               CNT_W    = $clog2(CMD_WIDTH);
    localparam logic [CNT_W-1:0] LAST_SPI = CNT_W'(CMD_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_QPI = CNT_W'(CMD_WIDTH / 4 - 1);
    localparam logic [4:0]       NREGS5   = 5'(NUM_REGS);
    localparam logic [7:0]       DUMMY8   = 8'(DUMMY_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic            get_addr;
        logic            get_mode;
        logic            get_data;
        logic            send_data;
        logic            enable_cont;
        logic            enable_regs;
        logic            wait_dummy;
        logic            error;
        logic [RS_W-1:0] reg_sel;
        logic [7:0]      dummy;
    } dec_t;

    // Value held by the decoded outputs while in reset: everything low
    // except error.
    localparam dec_t DEC_RST = '{error: 1'b1, default: '0};

    state_t               state, state_d;
    logic [CMD_WIDTH-1:0] sr, sr_nxt;
    logic [CNT_W-1:0]     cnt;
    logic                 qpi_q;
    logic                 mode_now;
    logic                 last_beat;
    logic                 capture;
    logic                 final_cap;
    logic                 abort;
    dec_t                 dec_q;

    // Map a complete command word to its phase controls.
    function automatic dec_t decode(input logic [CMD_WIDTH-1:0] c);
        dec_t       d;
        logic [7:0] b;
        logic [3:0] k;
        logic       k_ok;
        d    = '0;
        b    = c[7:0];
        k    = b[7:4];
        k_ok = ({1'b0, k} >= 5'd2) && ({1'b0, k} < NREGS5);
        if ((c >> 8) != '0) begin
            d.error = 1'b1;
        end else begin
            case (b)
                8'h01: begin
                    d.get_data    = 1'b1;
                    d.enable_regs = 1'b1;
                end
                8'h02: begin
                    d.get_addr    = 1'b1;
                    d.get_data    = 1'b1;
                    d.enable_cont = 1'b1;
                end
                8'h05: begin
                    d.send_data   = 1'b1;
                    d.enable_regs = 1'b1;
                end
                8'h07: begin
                    d.send_data   = 1'b1;
                    d.enable_regs = 1'b1;
                    d.reg_sel     = RS_W'(1);
                end
                8'h0B: begin
                    d.get_addr    = 1'b1;
                    d.send_data   = 1'b1;
                    d.enable_cont = 1'b1;
                    d.wait_dummy  = 1'b1;
                    d.dummy       = DUMMY8;
                end
                8'h11: begin
                    d.get_data    = 1'b1;
                    d.enable_regs = 1'b1;
                    d.reg_sel     = RS_W'(1);
                end
                default: begin
                    // 0xK0 / 0xK1 select register set K for K >= 2
                    if (b[3:0] == 4'h0 && k_ok) begin
                        d.get_data    = 1'b1;
                        d.enable_regs = 1'b1;
                        d.reg_sel     = k[RS_W-1:0];
                    end else if (b[3:0] == 4'h1 && k_ok) begin
                        d.send_data   = 1'b1;
                        d.enable_regs = 1'b1;
                        d.reg_sel     = k[RS_W-1:0];
                    end else begin
                        d.error = 1'b1;
                    end
                end
            endcase
        end
        return d;
    endfunction

    // The first beat uses the live mode pin; later beats use the latched copy
    // so a mid-command change of qpi_mode has no effect.
    assign mode_now  = (state == IDLE) ? qpi_mode : qpi_q;
    assign last_beat = (cnt == (mode_now ? LAST_QPI : LAST_SPI));
    assign sr_nxt    = mode_now ? {sr[CMD_WIDTH-5:0], sdi} : {sr[CMD_WIDTH-2:0], sdi[0]};

    // State register.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_d;
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_d   = state;
        capture   = 1'b0;
        final_cap = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    capture = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!en) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    capture = 1'b1;
                    if (last_beat) begin
                        final_cap = 1'b1;
                        state_d   = HOLD;
                    end
                end
            end
            HOLD: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Shift register, beat counter, command word and decoded fields.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            sr        <= '0;
            cnt       <= '0;
            qpi_q     <= 1'b0;
            cmd       <= '0;
            cmd_valid <= 1'b0;
            dec_q     <= DEC_RST;
        end else begin
            cmd_valid <= 1'b0;
            if (state == IDLE && en) qpi_q <= qpi_mode;
            if (abort) begin
                sr  <= '0;
                cnt <= '0;
            end else if (final_cap) begin
                sr        <= '0;
                cnt       <= '0;
                cmd       <= sr_nxt;
                dec_q     <= decode(sr_nxt);
                cmd_valid <= 1'b1;
            end else if (capture) begin
                sr  <= sr_nxt;
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Error counter: counts at the end of an error cmd_valid cycle, saturates,
    // and a simultaneous clear takes priority.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            err_cnt <= '0;
        end else if (err_clr) begin
            err_cnt <= '0;
        end else if (cmd_valid && dec_q.error && (err_cnt != '1)) begin
            err_cnt <= err_cnt + ERR_CNT_W'(1);
        end
    end

    assign get_addr     = dec_q.get_addr;
    assign get_mode     = dec_q.get_mode;
    assign get_data     = dec_q.get_data;
    assign send_data    = dec_q.send_data;
    assign enable_cont  = dec_q.enable_cont;
    assign enable_regs  = dec_q.enable_regs;
    assign wait_dummy   = dec_q.wait_dummy;
    assign error        = dec_q.error;
    assign reg_sel      = dec_q.reg_sel;
    assign dummy_cycles = dec_q.dummy;
    assign busy         = (state != IDLE);

endmodule
